uart_frame_check: RTL and testbench
===================================

Name: uart_frame_check

Overview:
Parametrised frame-tail checker for the UART receiver. It replaces single-purpose stop checking with one sequencer that checks the optional parity bit and one or two stop bits. It sits beside the RX FSM, edge counter and data sampler. It self-sequences through the frame tail using the edge count, and reports sticky parity and stop errors plus a completion pulse.

Parameters:
DATA_WIDTH, 8, width of received data word used for parity
PRESCALE_WIDTH, 6, width of prescale and edge_cnt

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  synchronous active-low reset
chk_start  input  1  single-cycle pulse: last data bit finished, parity/stop checking begins
data  input  DATA_WIDTH  received data word, valid while chk_start=1
par_en  input  1  1 = frame carries parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
stop2  input  1  1 = two stop bits, 0 = one
sampled_bit  input  1  majority-voted bit from data sampler, valid at sampling edge
edge_cnt  input  PRESCALE_WIDTH  oversampling edge counter, runs 0..prescale-1 per bit
prescale  input  PRESCALE_WIDTH  oversampling ratio
busy  output  1  checker active
par_err  output  1  sticky parity error
stp_err  output  1  sticky stop error (any stop bit sampled 0)
chk_done  output  1  one-cycle pulse when frame tail complete

Behaviour:
- Reset (RST=0 at CLK edge, any state): state IDLE; busy, par_err, stp_err, chk_done = 0; captured config cleared.
- States: IDLE, PAR, STP1, STP2, DONE.
- IDLE + chk_start=1: latch par_en, par_typ, stop2, prescale; expected parity exp_par = (^data) ^ par_typ. Clear par_err and stp_err. Next state is PAR if par_en, else STP1. busy=1 from next cycle.
- chk_start in PAR/STP1/STP2: ignored, no effect.
- Latched config and prescale are used for the whole frame. Input changes mid-frame are ignored.
- Effective prescale P: latched prescale if >= 4, else 8.
- Sampling time S = min((P>>1)+2, P-1). Examples: P=8 gives 6, P=16 gives 10, P=32 gives 18, P=4 gives 3. Integer floor for odd P.
- Bit end E = P-1.
- In PAR, at edge_cnt==S: par_err <= (sampled_bit != exp_par).
- In STP1/STP2, at edge_cnt==S: if sampled_bit==0, stp_err <= 1. A 1 does not clear stp_err, so the two stop bits OR together.
- At edge_cnt==E, advance:
  - PAR -> STP1
  - STP1 -> STP2 if stop2, else DONE
  - STP2 -> DONE
- If S==E in the same cycle, sample with the current state, then advance.
- An edge_cnt value equal to S held over several cycles re-samples. The result is idempotent for par_err; for stp_err it is the OR of the samples.
- DONE lasts exactly one cycle: chk_done=1, busy=1, then -> IDLE.
  - chk_start in the DONE cycle is accepted exactly as in IDLE (back-to-back frames). Errors clear and the new sequence starts; chk_done still pulses.
- par_err/stp_err hold their value after DONE until the next accepted chk_start or reset.
- busy=0 only in IDLE.
- Latency: chk_done asserts the cycle after the clock edge where edge_cnt==E in the last stop bit.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- DATA_WIDTH=8, prescale=8, par_en=1, par_typ=0, stop2=0, data=8'hA5; drive sampled_bit=0 at parity S=6, then 1 at stop S=6 -> par_err=0, stp_err=0, chk_done pulses 1 cycle after stop edge_cnt=7, busy falls the cycle after.
- Same frame, parity bit sampled 1 -> par_err=1 at edge_cnt=6 of parity bit, held after chk_done until next chk_start.
- prescale=16, par_en=0, stop2=1; stop1 sampled 0 at edge_cnt=10, stop2 sampled 1 -> stp_err=1 (sticky), chk_done after stop2 edge_cnt=15.
- prescale=32, par_typ=1, data=8'h01 (exp_par=0) -> sampling occurs only at edge_cnt=18. Sampled_bit forced wrong at all other edge counts leaves par_err=0. prescale=4 -> sampling at 3, advance on same cycle.
- Back-to-back: chk_start asserted in DONE cycle with errors previously set -> errors clear, new frame runs, chk_done still pulses once for the old frame. chk_start mid-STP1 -> ignored.
- RST=0 asserted mid-PAR for one cycle -> next cycle IDLE, all outputs 0. Subsequent edge_cnt activity causes no sampling until chk_start.

Source files
------------

// File: rtl/uart_frame_check.sv
// Frame-tail checker for the UART receiver: walks the optional parity bit and one
// or two stop bits using the shared edge counter, flagging sticky parity/stop errors.
module uart_frame_check #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      chk_start,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic                      stop2,
    input  logic                      sampled_bit,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      busy,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      chk_done
);

    // One extra bit so (P>>1)+2 cannot wrap for the largest prescale.
    localparam int CW = PRESCALE_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAR,
        S_STP1,
        S_STP2,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            stop2_q, stop2_d;
    logic            exp_par_q, exp_par_d;
    logic [CW-1:0]   samp_q, samp_d;
    logic [CW-1:0]   end_q, end_d;
    logic            par_err_q, par_err_d;
    logic            stp_err_q, stp_err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [CW-1:0]   p_eff;
    logic [CW-1:0]   half_plus2;
    logic [CW-1:0]   end_pt;
    logic [CW-1:0]   samp_pt;
    logic            at_samp;
    logic            at_end;
    logic            start_ok;

    // Sample and end points are derived from the prescale offered with chk_start
    // and frozen for the whole tail, so mid-frame prescale changes have no effect.
    always_comb begin
        p_eff      = (prescale >= PRESCALE_WIDTH'(4)) ? {1'b0, prescale} : CW'(8);
        half_plus2 = (p_eff >> 1) + CW'(2);
        end_pt     = p_eff - CW'(1);
        samp_pt    = (half_plus2 < end_pt) ? half_plus2 : end_pt;
    end

    assign at_samp  = ({1'b0, edge_cnt} == samp_q);
    assign at_end   = ({1'b0, edge_cnt} == end_q);
    assign start_ok = chk_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        stop2_d   = stop2_q;
        exp_par_d = exp_par_q;
        samp_d    = samp_q;
        end_d     = end_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;

        unique case (state_q)
            S_IDLE: ;
            S_PAR: begin
                if (at_samp) begin
                    par_err_d = (sampled_bit != exp_par_q);
                end
                if (at_end) begin
                    state_d = S_STP1;
                end
            end
            S_STP1: begin
                if (at_samp && !sampled_bit) begin
                    stp_err_d = 1'b1;
                end
                if (at_end) begin
                    state_d = stop2_q ? S_STP2 : S_DONE;
                end
            end
            S_STP2: begin
                if (at_samp && !sampled_bit) begin
                    stp_err_d = 1'b1;
                end
                if (at_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A start in DONE is taken like one in IDLE so frames can run back to back.
        if (start_ok) begin
            state_d   = par_en ? S_PAR : S_STP1;
            stop2_d   = stop2;
            exp_par_d = (^data) ^ par_typ;
            samp_d    = samp_pt;
            end_d     = end_pt;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            stop2_q   <= 1'b0;
            exp_par_q <= 1'b0;
            samp_q    <= '0;
            end_q     <= '0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stop2_q   <= stop2_d;
            exp_par_q <= exp_par_d;
            samp_q    <= samp_d;
            end_q     <= end_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign par_err  = par_err_q;
    assign stp_err  = stp_err_q;
    assign chk_done = done_q;

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed testbench for uart_frame_check: parity/stop sequencing, sample-point
// selection across prescales, back-to-back frames and synchronous reset.
module tb_uart_frame_check;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          chk_start;
    logic [DW-1:0] data;
    logic          par_en;
    logic          par_typ;
    logic          stop2;
    logic          sampled_bit;
    logic [PW-1:0] edge_cnt;
    logic [PW-1:0] prescale;
    logic          busy;
    logic          par_err;
    logic          stp_err;
    logic          chk_done;

    int checks   = 0;
    int failures = 0;

    uart_frame_check #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .chk_start  (chk_start),
        .data       (data),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .sampled_bit(sampled_bit),
        .edge_cnt   (edge_cnt),
        .prescale   (prescale),
        .busy       (busy),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .chk_done   (chk_done)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are observed 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic [PW-1:0] ps, input logic pe, input logic pt,
                               input logic s2, input logic [DW-1:0] d);
        prescale  = ps;
        par_en    = pe;
        par_typ   = pt;
        stop2     = s2;
        data      = d;
        chk_start = 1'b1;
        tick();
        chk_start = 1'b0;
    endtask

    // Runs one bit period (edge_cnt 0..p-1) and reports what the outputs showed.
    task automatic drive_bit(input int p, input int s, input logic v_s, input logic v_other,
                             output logic pe_pre, output logic se_pre,
                             output logic pe_s, output logic se_s, output logic early_done);
        pe_pre = 1'b0; se_pre = 1'b0; pe_s = 1'b0; se_s = 1'b0; early_done = 1'b0;
        for (int ec = 0; ec < p; ec++) begin
            edge_cnt    = PW'(ec);
            sampled_bit = (ec == s) ? v_s : v_other;
            tick();
            if (ec < s) begin
                pe_pre = pe_pre | par_err;
                se_pre = se_pre | stp_err;
            end
            if (ec == s) begin
                pe_s = par_err;
                se_s = stp_err;
            end
            if (ec < p - 1) early_done = early_done | chk_done;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; chk_start = 1'b0; data = '0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        sampled_bit = 1'b1; edge_cnt = '0; prescale = PW'(8);
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL reset_par_err: got %b want 0", par_err); end
        checks++; if (stp_err !== 1'b0) begin failures++; $display("FAIL reset_stp_err: got %b want 0", stp_err); end
        checks++; if (chk_done !== 1'b0) begin failures++; $display("FAIL reset_chk_done: got %b want 0", chk_done); end
        RST = 1'b1;
        tick();
    endtask

    // P=8, even parity, data A5 (exp_par 0), parity sampled 0, one good stop bit.
    task automatic test_basic();
        logic a, b, c, d, e;
        start_frame(PW'(8), 1'b1, 1'b0, 1'b0, 8'hA5);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start: got %b want 1", busy); end
        drive_bit(8, 6, 1'b0, 1'b0, a, b, c, d, e);
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL basic_par_at_s: got %b want 0", c); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_par_early_done: got %b want 0", e); end
        drive_bit(8, 6, 1'b1, 1'b1, a, b, c, d, e);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_stp_early_done: got %b want 0", e); end
        checks++; if (chk_done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b want 1", chk_done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done: got %b want 1", busy); end
        checks++; if ({par_err, stp_err} !== 2'b00) begin failures++; $display("FAIL basic_errs: got %b want 00", {par_err, stp_err}); end
        tick();
        checks++; if (chk_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b want 0", chk_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
    endtask

    // Same frame with the parity bit sampled 1: par_err rises at edge 6 and is held.
    task automatic test_par_err();
        logic a, b, c, d, e;
        start_frame(PW'(8), 1'b1, 1'b0, 1'b0, 8'hA5);
        drive_bit(8, 6, 1'b1, 1'b0, a, b, c, d, e);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL parerr_pre: got %b want 0", a); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL parerr_at_s: got %b want 1", c); end
        drive_bit(8, 6, 1'b1, 1'b1, a, b, c, d, e);
        checks++; if (chk_done !== 1'b1) begin failures++; $display("FAIL parerr_done: got %b want 1", chk_done); end
        tick(); tick(); tick();
        checks++; if (par_err !== 1'b1) begin failures++; $display("FAIL parerr_held: got %b want 1", par_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL parerr_idle_busy: got %b want 0", busy); end
    endtask

    // P=16, no parity, two stop bits: stop1 bad at edge 10 stays sticky through stop2.
    task automatic test_stop2_p16();
        logic a, b, c, d, e;
        start_frame(PW'(16), 1'b0, 1'b0, 1'b1, 8'h3C);
        checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL stp16_par_cleared: got %b want 0", par_err); end
        drive_bit(16, 10, 1'b0, 1'b1, a, b, c, d, e);
        checks++; if (b !== 1'b0) begin failures++; $display("FAIL stp16_pre: got %b want 0", b); end
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL stp16_at_s: got %b want 1", d); end
        checks++; if (chk_done !== 1'b0) begin failures++; $display("FAIL stp16_done_after_stop1: got %b want 0", chk_done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stp16_busy_stop2: got %b want 1", busy); end
        drive_bit(16, 10, 1'b1, 1'b1, a, b, c, d, e);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL stp16_early_done: got %b want 0", e); end
        checks++; if (chk_done !== 1'b1) begin failures++; $display("FAIL stp16_done: got %b want 1", chk_done); end
        checks++; if (stp_err !== 1'b1) begin failures++; $display("FAIL stp16_sticky: got %b want 1", stp_err); end
        tick();
    endtask

    // P=32 samples only at 18; P=4 samples at 3 and advances the same cycle;
    // P=2 falls back to P=8.
    task automatic test_sample_points();
        logic a, b, c, d, e;
        start_frame(PW'(32), 1'b1, 1'b1, 1'b0, 8'h01);
        drive_bit(32, 18, 1'b0, 1'b1, a, b, c, d, e);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL p32_par_pre: got %b want 0", a); end
        checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL p32_par_end: got %b want 0", par_err); end
        drive_bit(32, 18, 1'b1, 1'b0, a, b, c, d, e);
        checks++; if (b !== 1'b0) begin failures++; $display("FAIL p32_stp_pre: got %b want 0", b); end
        checks++; if (stp_err !== 1'b0) begin failures++; $display("FAIL p32_stp_end: got %b want 0", stp_err); end
        checks++; if (chk_done !== 1'b1) begin failures++; $display("FAIL p32_done: got %b want 1", chk_done); end
        tick();

        start_frame(PW'(4), 1'b1, 1'b0, 1'b0, 8'h03);
        drive_bit(4, 3, 1'b1, 1'b0, a, b, c, d, e);
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL p4_par_at_s: got %b want 1", c); end
        drive_bit(4, 3, 1'b1, 1'b0, a, b, c, d, e);
        checks++; if (d !== 1'b0) begin failures++; $display("FAIL p4_stp_at_s: got %b want 0", d); end
        checks++; if (chk_done !== 1'b1) begin failures++; $display("FAIL p4_done: got %b want 1", chk_done); end
        tick();

        start_frame(PW'(2), 1'b0, 1'b0, 1'b0, 8'h00);
        drive_bit(8, 6, 1'b0, 1'b1, a, b, c, d, e);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL p2_stp_at_s: got %b want 1", d); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL p2_early_done: got %b want 0", e); end
        checks++; if (chk_done !== 1'b1) begin failures++; $display("FAIL p2_done: got %b want 1", chk_done); end
        tick();
    endtask

    // Restart accepted in the DONE cycle; a chk_start mid-STP1 is ignored.
    task automatic test_back_to_back();
        logic a, b, c, d, e;
        logic early;
        start_frame(PW'(8), 1'b1, 1'b0, 1'b0, 8'h00);
        drive_bit(8, 6, 1'b1, 1'b1, a, b, c, d, e);
        drive_bit(8, 6, 1'b0, 1'b1, a, b, c, d, e);
        checks++; if ({chk_done, par_err, stp_err} !== 3'b111) begin failures++; $display("FAIL b2b_old_done: got %b want 111", {chk_done, par_err, stp_err}); end
        start_frame(PW'(8), 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if ({par_err, stp_err} !== 2'b00) begin failures++; $display("FAIL b2b_errs_cleared: got %b want 00", {par_err, stp_err}); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", busy); end
        checks++; if (chk_done !== 1'b0) begin failures++; $display("FAIL b2b_single_pulse: got %b want 0", chk_done); end
        early = 1'b0;
        for (int ec = 0; ec < 8; ec++) begin
            edge_cnt    = PW'(ec);
            sampled_bit = 1'b1;
            chk_start   = (ec == 3);
            if (ec == 3) begin
                prescale = PW'(16);
                par_en   = 1'b1;
            end
            tick();
            if (ec < 7) early = early | chk_done;
        end
        chk_start = 1'b0;
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL b2b_early_done: got %b want 0", early); end
        checks++; if (chk_done !== 1'b1) begin failures++; $display("FAIL b2b_new_done: got %b want 1", chk_done); end
        checks++; if ({par_err, stp_err} !== 2'b00) begin failures++; $display("FAIL b2b_new_errs: got %b want 00", {par_err, stp_err}); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    // Reset pulse in PAR after par_err has been set; edge activity afterwards is ignored.
    task automatic test_reset_mid();
        logic any_out;
        start_frame(PW'(8), 1'b1, 1'b0, 1'b0, 8'h00);
        for (int ec = 0; ec < 7; ec++) begin
            edge_cnt    = PW'(ec);
            sampled_bit = 1'b1;
            tick();
        end
        checks++; if (par_err !== 1'b1) begin failures++; $display("FAIL rstmid_par_set: got %b want 1", par_err); end
        RST      = 1'b0;
        edge_cnt = PW'(7);
        tick();
        RST = 1'b1;
        checks++; if ({busy, par_err, stp_err, chk_done} !== 4'b0000) begin failures++; $display("FAIL rstmid_outputs: got %b want 0000", {busy, par_err, stp_err, chk_done}); end
        any_out = 1'b0;
        for (int n = 0; n < 16; n++) begin
            edge_cnt    = PW'(n % 8);
            sampled_bit = (n < 8);
            tick();
            any_out = any_out | busy | par_err | stp_err | chk_done;
        end
        checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL rstmid_quiet: got %b want 0", any_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_par_err();
        test_stop2_p16();
        test_sample_points();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
